mem_access_ctrl: RTL and testbench

Load/store sequencer in the MEM stage, between the pipeline and the data RAM. Decodes access size and address into per-lane byte enables, runs a req/ack handshake with variable-latency data memory, and stalls the pipeline until completion. Drives `ls_sel`/`load_usign` of the load-data extension register so extended load data appears with the `done` pulse. Flags misaligned accesses.

---
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: lane decode, req/ack handshake with the data RAM, stall/done.
// Optional feature macro: ALIGN_CHECK_EN (misalignment / illegal-size detection).

module mac_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  offs,
  input  logic [31:0] wdata,
  output logic        en,
  output logic [7:0]  data
);
  localparam logic [1:0] LID = LANE[1:0];

  always_comb begin
    en   = 1'b0;
    data = wdata[7:0];
    case (size)
      2'b00: begin
        en   = (offs == LID);
        data = wdata[7:0];
      end
      2'b01: begin
        en   = (offs[1] == LID[1]);
        data = LID[0] ? wdata[15:8] : wdata[7:0];
      end
      default: begin
        en   = 1'b1;
        data = wdata[8*LANE +: 8];
      end
    endcase
  end
endmodule

module mem_access_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_en,
  input  logic          mem_wr,
  input  logic [1:0]    size,
  input  logic          usign,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          dmem_req,
  output logic [3:0]    dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  output logic [3:0]    ls_sel,
  output logic          load_usign,
  output logic          stall,
  output logic          done,
  output logic          addr_err
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                       state, state_nxt;
  logic [1:0]                   size_eff;
  logic                         legal, accept;
  logic [NUM_LANES-1:0]         lane_en;
  logic [NUM_LANES-1:0][7:0]    lane_data;

  // Without the check, size 11 behaves as a word and every access is legal.
  always_comb begin
`ifdef ALIGN_CHECK_EN
    size_eff = size;
    case (size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~addr[0];
      2'b10:   legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
`else
    size_eff = (size == 2'b11) ? 2'b10 : size;
    legal    = 1'b1;
`endif
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mac_lane #(.LANE(l)) u_lane (
      .size  (size_eff),
      .offs  (addr[1:0]),
      .wdata (wdata[31:0]),
      .en    (lane_en[l]),
      .data  (lane_data[l])
    );
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (mem_en && legal) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (dmem_ack) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    addr_err = (state == IDLE) && mem_en && !legal;
    stall    = accept || (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      ls_sel     <= '0;
      load_usign <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == BUSY) && dmem_ack;
      if (accept) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_wr ? lane_en : 4'b0000;
        dmem_addr  <= {addr[AW-1:2], 2'b00};
        dmem_wdata <= lane_data;
        ls_sel     <= mem_wr ? 4'b0000 : lane_en;
        load_usign <= !mem_wr && usign;
      end
      if (state == BUSY && dmem_ack) begin
        dmem_req <= 1'b0;
        dmem_we  <= 4'b0000;
      end
      // Lane select stays up through RESP so the extended value lines up with done.
      if (state == RESP) begin
        ls_sel     <= 4'b0000;
        load_usign <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized + directed bench for mem_access_ctrl with a transaction-level reference model
// and a behavioural load-extension register.
module tb_mem_access_ctrl;
  logic        clk, rst;
  logic        mem_en, mem_wr, usign, dmem_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        dmem_req, load_usign, stall, done, addr_err;
  logic [3:0]  dmem_we, ls_sel;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] ext_q;
  int          n_chk, n_fail;

  mem_access_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .size(size),
    .usign(usign), .addr(addr), .wdata(wdata), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .ls_sel(ls_sel), .load_usign(load_usign),
    .stall(stall), .done(done), .addr_err(addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External extension register: samples memory data with ls_sel on the ack cycle.
  function automatic logic [31:0] ext_f(input logic [31:0] d, input logic [3:0] sel, input logic u);
    case (sel)
      4'b0001: ext_f = u ? {24'h0, d[7:0]}   : {{24{d[7]}},  d[7:0]};
      4'b0010: ext_f = u ? {24'h0, d[15:8]}  : {{24{d[15]}}, d[15:8]};
      4'b0100: ext_f = u ? {24'h0, d[23:16]} : {{24{d[23]}}, d[23:16]};
      4'b1000: ext_f = u ? {24'h0, d[31:24]} : {{24{d[31]}}, d[31:24]};
      4'b0011: ext_f = u ? {16'h0, d[15:0]}  : {{16{d[15]}}, d[15:0]};
      4'b1100: ext_f = u ? {16'h0, d[31:16]} : {{16{d[31]}}, d[31:16]};
      4'b1111: ext_f = d;
      default: ext_f = 32'h0;
    endcase
  endfunction

  always @(posedge clk) if (dmem_ack) ext_q <= ext_f(rdata, ls_sel, load_usign);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access: ack arrives in BUSY cycle k (k>=1), so done lands k+1 cycles after accept.
  // hold=1 keeps mem_en and the inputs asserted through RESP (back-to-back traffic).
  task automatic do_txn(input bit wr, input logic [1:0] sz, input bit us, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int k, input bit hold);
    logic [3:0]  lanes;
    logic [31:0] exp_wd, exp_ld, sh;
    bit          legal;
    int          off;
    legal = 1'b1;
`ifdef ALIGN_CHECK_EN
    legal = !(sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
`endif
    case (sz)
      2'b00:   begin off = int'(a[1:0]);  lanes = 4'b0001 << off; exp_wd = {4{wd[7:0]}}; end
      2'b01:   begin off = a[1] ? 2 : 0;  lanes = 4'b0011 << off; exp_wd = {2{wd[15:0]}}; end
      default: begin off = 0;             lanes = 4'b1111;        exp_wd = wd; end
    endcase
    sh = rd >> (8 * off);
    case (sz)
      2'b00:   exp_ld = us ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'b01:   exp_ld = us ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: exp_ld = rd;
    endcase

    mem_en = 1'b1; mem_wr = wr; size = sz; usign = us; addr = a; wdata = wd; dmem_ack = 1'b0;
    #1;
    chk("stall_at_accept", stall, legal);
    chk("addr_err", addr_err, !legal);
    @(posedge clk); #1;
    if (!legal) begin
      chk("no_req_illegal", dmem_req, 0);
      chk("no_stall_illegal", stall, 0);
      mem_en = 1'b0;
      return;
    end
    for (int c = 1; c <= k; c++) begin
      if (!hold) begin
        mem_en = 1'b0; addr = $urandom; wdata = $urandom;
        mem_wr = 1'($urandom); size = 2'($urandom); usign = 1'($urandom);
      end
      dmem_ack = (c == k);
      rdata    = (c == k) ? rd : $urandom;
      #1;
      chk("busy_req", dmem_req, 1);
      chk("busy_we", dmem_we, wr ? lanes : 4'b0000);
      chk("busy_addr", dmem_addr, {a[31:2], 2'b00});
      if (wr) chk("busy_wdata", dmem_wdata, exp_wd);
      chk("busy_ls_sel", ls_sel, wr ? 4'b0000 : lanes);
      chk("busy_usign", load_usign, !wr && us);
      chk("busy_stall", stall, 1);
      chk("busy_done", done, 0);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    #1;
    chk("resp_done", done, 1);
    chk("resp_stall", stall, 0);
    chk("resp_req", dmem_req, 0);
    chk("resp_we", dmem_we, 0);
    chk("resp_ls_sel", ls_sel, wr ? 4'b0000 : lanes);
    chk("resp_usign", load_usign, !wr && us);
    if (!wr) chk("load_value", ext_q, exp_ld);
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_ls_sel", ls_sel, 0);
    chk("idle_usign", load_usign, 0);
    if (!hold) mem_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_ls_sel"}, ls_sel, 0);
    chk({tag, "_usign"}, load_usign, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr_err"}, addr_err, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; size = 2'b00; usign = 1'b0;
    addr = '0; wdata = '0; rdata = '0; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Plan vectors.
    do_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3, 1'b0);
    do_txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 1'b0);
    do_txn(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AB, 32'h0, 2, 1'b0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
    do_txn(1'b1, 2'b01, 1'b0, 32'h0000_0032, 32'h1234_BEEF, 32'h0, 1, 1'b0);

    // Ack outside BUSY is ignored.
    dmem_ack = 1'b1; #1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("stray_ack_done", done, 0);
    chk("stray_ack_req", dmem_req, 0);
    @(posedge clk); #1;
    chk("stray_ack_done2", done, 0);

    // Reset on the second BUSY cycle, late ack afterwards.
    mem_en = 1'b1; mem_wr = 1'b0; size = 2'b10; usign = 1'b0; addr = 32'h40;
    @(posedge clk); #1;
    mem_en = 1'b0;
    chk("pre_rst_req", dmem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    dmem_ack = 1'b0; #1;
    chk("late_ack_done", done, 0);
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_stall", stall, 0);
    @(posedge clk); #1;
    chk("late_ack_done2", done, 0);

    // Back-to-back with mem_en held through RESP.
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h8765_4321, 2, 1'b1);
    do_txn(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'hFEDC_BA98, 1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(1, 4)), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        mem_en = 1'b0;
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
